// File: rtl/player_speed_pkg.sv
// rtl/player_speed_pkg.sv - shared types, constants and saturating helpers for player_speed_ctrl
//
// Contents:
//   speed_state_t  : 2-bit FSM state (IDLE=0, DRIVE=1, CRASH=2, FINISH=3)
//   SPEED_W        : width of player_speed
//   TURBO_MAX_SPEED: speed ceiling while turbo is compiled in (TURBO_EN)
//   DEF_*          : default step / ceiling / hold constants
//   sat_add/sat_sub: 11-bit saturating arithmetic on speed values
package player_speed_pkg;

  localparam int SPEED_W          = 10;
  localparam int TURBO_MAX_SPEED  = 960;

  localparam int DEF_MAX_SPEED    = 800;
  localparam int DEF_ACCEL_STEP   = 8;
  localparam int DEF_COAST_STEP   = 2;
  localparam int DEF_BRAKE_STEP   = 16;
  localparam int DEF_CRASH_FRAMES = 60;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    CRASH  = 2'd2,
    FINISH = 2'd3
  } speed_state_t;

  // One extra bit of headroom so sums cannot wrap before clamping.
  typedef logic [SPEED_W:0]   speed_ext_t;
  typedef logic [SPEED_W-1:0] speed_t;

  function automatic speed_t sat_add(input speed_t v, input speed_ext_t step,
                                     input speed_ext_t lim);
    speed_ext_t sum;
    sum = {1'b0, v} + step;
    if (sum > lim) sum = lim;
    return sum[SPEED_W-1:0];
  endfunction

  function automatic speed_t sat_sub(input speed_t v, input speed_ext_t step);
    speed_ext_t diff;
    if ({1'b0, v} < step) diff = '0;
    else                  diff = {1'b0, v} - step;
    return diff[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// rtl/frame_countdown.sv - loadable per-frame down-counter used for the crash hold
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   load       : load load_val this cycle (wins over tick)
//   load_val   : value to load
//   tick       : decrement by one (stops at zero)
//   done       : count currently equals 1, i.e. the next tick expires it
module frame_countdown #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = load_val;
    else if (tick && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/player_speed_ctrl.sv
// rtl/player_speed_ctrl.sv - per-frame player speed profile (accel, coast, brake, crash, finish)
//
// Optional feature macro: TURBO_EN (adds turbo_key, ceiling TURBO_MAX_SPEED).
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   startOfFrame  : one-cycle pulse per video frame; all speed steps happen here
//   race_active   : level, race running; low forces IDLE / speed 0
//   gas_key       : accelerate request
//   brake_key     : brake request (beats gas)
//   turbo_key     : (TURBO_EN only) double acceleration with gas
//   crash         : one-cycle collision pulse
//   finish_line   : level, run-down to zero
//   player_speed  : registered current speed
//   speed_state   : registered FSM state encoding
//   crash_active  : registered, high while in CRASH
module player_speed_ctrl
  import player_speed_pkg::*;
#(
  parameter int MAX_SPEED    = DEF_MAX_SPEED,
  parameter int ACCEL_STEP   = DEF_ACCEL_STEP,
  parameter int COAST_STEP   = DEF_COAST_STEP,
  parameter int BRAKE_STEP   = DEF_BRAKE_STEP,
  parameter int CRASH_FRAMES = DEF_CRASH_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               race_active,
  input  logic               gas_key,
  input  logic               brake_key,
`ifdef TURBO_EN
  input  logic               turbo_key,
`endif
  input  logic               crash,
  input  logic               finish_line,
  output logic [SPEED_W-1:0] player_speed,
  output logic [1:0]         speed_state,
  output logic               crash_active
);

  localparam int CNT_W = $clog2(CRASH_FRAMES + 1);

  localparam speed_ext_t MAX_C   = speed_ext_t'(MAX_SPEED);
  localparam speed_ext_t TMAX_C  = speed_ext_t'(TURBO_MAX_SPEED);
  localparam speed_ext_t ACCEL_C = speed_ext_t'(ACCEL_STEP);
  localparam speed_ext_t TACC_C  = speed_ext_t'(2 * ACCEL_STEP);
  localparam speed_ext_t COAST_C = speed_ext_t'(COAST_STEP);
  localparam speed_ext_t BRAKE_C = speed_ext_t'(BRAKE_STEP);

  speed_state_t state_q, state_d;
  speed_t       speed_q, speed_d;
  logic         crash_active_q;

  logic             cnt_load, cnt_tick, cnt_done;
  logic [CNT_W-1:0] cnt_val;
  logic             turbo_req;

`ifdef TURBO_EN
  assign turbo_req = turbo_key;
`else
  assign turbo_req = 1'b0;
`endif

  frame_countdown #(.W(CNT_W)) u_crash_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tick     (cnt_tick),
    .done     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    cnt_load = 1'b0;
    cnt_val  = CNT_W'(CRASH_FRAMES);
    cnt_tick = 1'b0;

    if (!race_active) begin
      state_d  = IDLE;
      speed_d  = '0;
      // Clear a crash hold abandoned mid-way so the counter is idle again.
      cnt_load = 1'b1;
      cnt_val  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (startOfFrame) state_d = DRIVE;
        end
        DRIVE: begin
          if (finish_line) begin
            state_d = FINISH;
          end else if (crash) begin
            state_d  = CRASH;
            speed_d  = '0;
            cnt_load = 1'b1;
          end else if (startOfFrame) begin
            if (brake_key)                    speed_d = sat_sub(speed_q, BRAKE_C);
            else if (gas_key && turbo_req)    speed_d = sat_add(speed_q, TACC_C, TMAX_C);
            // Speed left above the normal ceiling by turbo bleeds off even with gas.
            else if (gas_key && {1'b0, speed_q} > MAX_C)
                                              speed_d = sat_sub(speed_q, COAST_C);
            else if (gas_key)                 speed_d = sat_add(speed_q, ACCEL_C, MAX_C);
            else                              speed_d = sat_sub(speed_q, COAST_C);
          end
        end
        CRASH: begin
          speed_d = '0;
          // A fresh crash reloads the hold, even on the frame it would expire.
          if (crash) begin
            cnt_load = 1'b1;
          end else if (startOfFrame) begin
            cnt_tick = 1'b1;
            if (cnt_done) state_d = DRIVE;
          end
        end
        FINISH: begin
          if (startOfFrame) speed_d = sat_sub(speed_q, BRAKE_C);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      speed_q        <= '0;
      crash_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      speed_q        <= speed_d;
      crash_active_q <= (state_d == CRASH);
    end
  end

  assign player_speed = speed_q;
  assign speed_state  = state_q;
  assign crash_active = crash_active_q;

endmodule

// File: tb/tb_player_speed_ctrl.sv
// tb/tb_player_speed_ctrl.sv - self-checking bench for player_speed_ctrl (directed + random vs model)
module tb_player_speed_ctrl;

  localparam int MAXS = 800;
  localparam int TMAX = 960;
  localparam int ACC  = 8;
  localparam int CST  = 2;
  localparam int BRK  = 16;
  localparam int CF   = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       sof, race, gas, brake, turbo, crash, fin;
  logic [9:0] player_speed;
  logic [1:0] speed_state;
  logic       crash_active;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: speed as an integer, state as a small integer code.
  int m_state, m_speed, m_cnt;

  always #5 clk = ~clk;

  player_speed_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (sof),
    .race_active  (race),
    .gas_key      (gas),
    .brake_key    (brake),
`ifdef TURBO_EN
    .turbo_key    (turbo),
`endif
    .crash        (crash),
    .finish_line  (fin),
    .player_speed (player_speed),
    .speed_state  (speed_state),
    .crash_active (crash_active)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_speed = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    int t;
`ifdef TURBO_EN
    t = int'(turbo);
`else
    t = 0;
`endif
    if (!race) begin
      m_state = 0; m_speed = 0; m_cnt = 0;
    end else if (m_state == 0) begin
      if (sof) m_state = 1;
    end else if (m_state == 1) begin
      if (fin) m_state = 3;
      else if (crash) begin
        m_state = 2; m_speed = 0; m_cnt = CF;
      end else if (sof) begin
        if (brake)                      m_speed = imax(m_speed - BRK, 0);
        else if (gas && t != 0)         m_speed = imin(m_speed + 2 * ACC, TMAX);
        else if (gas && m_speed > MAXS) m_speed = m_speed - CST;
        else if (gas)                   m_speed = imin(m_speed + ACC, MAXS);
        else                            m_speed = imax(m_speed - CST, 0);
      end
    end else if (m_state == 2) begin
      if (crash) m_cnt = CF;
      else if (sof) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_state = 1;
      end
    end else begin
      if (sof) m_speed = imax(m_speed - BRK, 0);
    end
  endtask

  // One clock: apply pulses, let the edge happen, advance model, compare.
  task automatic cyc(input logic s, input logic c);
    sof   = s;
    crash = c;
    @(posedge clk);
    #1;
    model_step();
    check_eq("speed", int'(player_speed), m_speed);
    check_eq("state", int'(speed_state), m_state);
    check_eq("crash_active", int'(crash_active), int'(m_state == 2));
    sof   = 1'b0;
    crash = 1'b0;
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b0);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    sof = 0; race = 0; gas = 0; brake = 0; turbo = 0; crash = 0; fin = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_speed", int'(player_speed), 0);
    check_eq("rst_state", int'(speed_state), 0);
    check_eq("rst_crash_active", int'(crash_active), 0);
    reset = 1'b0;

    // Gas from rest: first frame only leaves IDLE, then +8 per frame.
    race = 1; gas = 1;
    frame(1);
    check_eq("idle_to_drive", int'(speed_state), 1);
    check_eq("first_frame_speed", int'(player_speed), 0);
    for (int k = 2; k <= 10; k++) begin
      frame(1);
      check_eq("accel_ramp", int'(player_speed), 8 * (k - 1));
    end

    // Saturation, then brake beats gas.
    frame(120);
    check_eq("sat_max", int'(player_speed), MAXS);
    brake = 1;
    for (int k = 1; k <= 3; k++) begin
      frame(1);
      check_eq("brake_with_gas", int'(player_speed), MAXS - 16 * k);
    end

    // Brake to 0, build to 10, then coast without underflow.
    gas = 0;
    frame(47);
    check_eq("brake_to_zero", int'(player_speed), 0);
    brake = 0; gas = 1;
    frame(2);
    gas = 0;
    frame(3);
    check_eq("speed_ten", int'(player_speed), 10);
    for (int k = 1; k <= 6; k++) begin
      frame(1);
      check_eq("coast_floor", int'(player_speed), imax(10 - 2 * k, 0));
    end

    // Crash at 400 on a frame pulse; re-crash after 30 frames.
    gas = 1;
    frame(50);
    check_eq("speed_400", int'(player_speed), 400);
    cyc(1'b1, 1'b1);
    check_eq("crash_speed", int'(player_speed), 0);
    check_eq("crash_flag", int'(crash_active), 1);
    frame(30);
    check_eq("still_crash", int'(speed_state), 2);
    cyc(1'b0, 1'b1);
    n = 0;
    while (speed_state == 2'd2 && n < 100) begin
      frame(1);
      n++;
    end
    check_eq("crash_hold_frames", 30 + n, 90);
    check_eq("post_crash_speed", int'(player_speed), 0);

    // Finish run-down from 100 with gas held.
    frame(13);
    gas = 0;
    frame(2);
    check_eq("speed_100", int'(player_speed), 100);
    gas = 1; fin = 1;
    cyc(1'b0, 1'b0);
    check_eq("enter_finish", int'(speed_state), 3);
    for (int k = 1; k <= 7; k++) begin
      frame(1);
      check_eq("rundown", int'(player_speed), imax(100 - 16 * k, 0));
    end
    frame(2);
    check_eq("finish_hold", int'(speed_state), 3);
    cyc(1'b0, 1'b1);
    check_eq("finish_ignores_crash", int'(speed_state), 3);
    race = 0;
    cyc(1'b0, 1'b0);
    check_eq("race_off_idle", int'(speed_state), 0);

    // Asynchronous reset in the middle of a crash hold.
    race = 1; fin = 0; gas = 1;
    frame(6);
    cyc(1'b0, 1'b1);
    check_eq("pre_reset_crash", int'(speed_state), 2);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_state", int'(speed_state), 0);
    check_eq("async_rst_flag", int'(crash_active), 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (race) begin
        if ($urandom_range(0, 399) == 0) race = 0;
      end else if ($urandom_range(0, 4) == 0) race = 1;
      if ($urandom_range(0, 15) == 0) gas   = ~gas;
      if ($urandom_range(0, 23) == 0) brake = ~brake;
      if ($urandom_range(0, 19) == 0) turbo = ~turbo;
      if ($urandom_range(0, 299) == 0) fin  = ~fin;
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
